aes_mix_columns_seq: RTL
========================

Name: aes_mix_columns_seq

Overview:
- Sequential MixColumns stage, directly downstream of the ShiftRows block in the AES round datapath.
- Accepts a 16-byte shifted state through a valid/ready handshake.
- Applies the GF(2^8) MixColumns transform a fixed number of columns per cycle, holds the result until the consumer accepts it.
- A per-transaction bypass serves the final round, which has no MixColumns.

Parameters:
- COLS_PER_CYCLE, 1, columns processed per clock; legal values 1, 2, 4; any other value is an elaboration error.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream holds in_state valid.
- in_ready  output  1  block can accept a state.
- in_bypass  input  1  sampled with the state; 1 = pass the state through unchanged (final round).
- in_state  input  [7:0] x [15:0]  input state, unpacked byte array.
- out_valid  output  1  out_val holds a completed result.
- out_ready  input  1  downstream accepts out_val.
- out_val  output  [7:0] x [15:0]  result, same byte layout as in_state.

Behaviour:
- Byte layout, same as ShiftRows:
  - Column c (c = 0..3) = bytes {15-4c, 14-4c, 13-4c, 12-4c} = rows 0..3.
  - Byte 15 is row 0 of column 0.
- Per column (a0..a3 = rows 0..3), computed in GF(2^8), poly 0x11B:
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
  - xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0x00).
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_state and in_bypass into an internal work register, clear column counter col_cnt. Go to BYPASS if in_bypass=1, else BUSY.
  - BUSY: each cycle, transform COLS_PER_CYCLE columns of the work register in place, starting at column col_cnt and moving upward. col_cnt advances by COLS_PER_CYCLE. When the last column is written, go to DONE. col_cnt width is 2 bits and must not wrap into a 5th pass.
  - BYPASS: one cycle, no transform, go to DONE. Total latency matches a single-column pass.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- in_ready is 0 in BUSY, BYPASS and DONE. There is no overlap: the next accept occurs at the earliest in the cycle after the out handshake.
- Latency: from the accept edge to the first out_valid=1 cycle is 4/COLS_PER_CYCLE edges for BUSY (4, 2 or 1), and 1 edge for BYPASS.
- out_val is driven directly from the work register.
  - out_val is stable while out_valid=1 and out_ready=0.
  - Its content is don't-care when out_valid=0. The bench compares only on out handshake.
- in_state and in_bypass are ignored outside the IDLE accept cycle.
- Reset:
  - On rst=1 at an edge: state = IDLE, col_cnt = 0, work register = 0.
  - Output values during and after reset: out_valid=0, in_ready=1, out_val=0.
  - Reset mid-operation (BUSY/BYPASS/DONE) aborts the transaction and produces no output.
  - rst has priority over any simultaneous handshake.

Optional Feature:
- Macro AES_MIX_INV_EN.
- When defined:
  - Adds input port in_inv (1 bit), sampled with in_state. When in_inv=1, BUSY applies InvMixColumns:
    - b0 = 14a0^11a1^13a2^9a3
    - b1 = 9a0^14a1^11a2^13a3
    - b2 = 13a0^9a1^14a2^11a3
    - b3 = 11a0^13a1^9a2^14a3
  - Latency is unchanged.
  - in_bypass=1 overrides in_inv.
- When undefined: there is no in_inv port, and the logic is forward-only.

Decomposition:
- Shared package aes_pkg holds:
  - typedef aes_byte_t (8-bit)
  - typedef aes_state_t (16 x aes_byte_t)
  - constant AES_POLY_RED = 8'h1B
  - functions xtime and gf_mul
  - FSM state enum.
- Sub-module aes_mix_col_one: combinational, one 4-byte column in, one 4-byte column out, plus an inv input under AES_MIX_INV_EN. It is instantiated COLS_PER_CYCLE times.

Test Plan:
- Forward column vectors, with COLS_PER_CYCLE=1 and column 0 = db 13 53 45, col1 = f2 0a 22 5c, col2 = 01 01 01 01, col3 = d4 d4 d4 d5 -> out cols 8e 4d a1 bc, 9f dc 58 9d, 01 01 01 01, d5 d5 d7 d6. First out_valid occurs 4 edges after accept.
- Parameter sweep, COLS_PER_CYCLE = 2 and 4 with the same vectors -> identical results at latency 2 and 1 edges.
- Bypass, in_bypass=1 with state 00..0f -> out_val equals in_state exactly, out_valid 1 edge after accept.
- Backpressure, out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_val stable, in_ready=0, a new in_valid is ignored. Assert out_ready -> the next accept occurs only in the following cycle.
- Reset mid-BUSY, assert rst at col_cnt=2 -> next cycle out_valid=0, in_ready=1, out_val=0, no output is produced. Then a fresh transaction completes correctly.
- Inverse, with AES_MIX_INV_EN defined: in_inv=1, column 8e 4d a1 bc -> db 13 53 45. Round trip forward then inverse on random states returns the original state.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, GF(2^8) helpers and the MixColumns FSM state encoding.
// Used by aes_mix_col_one and aes_mix_columns_seq.
package aes_pkg;

  typedef logic [7:0] aes_byte_t;
  typedef aes_byte_t  aes_state_t [16];

  localparam aes_byte_t AES_POLY_RED = 8'h1B;

  // state     | meaning
  // ST_IDLE   | ready for a new state from ShiftRows
  // ST_BUSY   | transforming columns of the work register in place
  // ST_BYPASS | final round: one idle cycle, no transform
  // ST_DONE   | result held on out_val until the consumer takes it
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_BYPASS = 2'd2,
    ST_DONE   = 2'd3
  } aes_mc_state_e;

  function automatic aes_byte_t xtime(input aes_byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY_RED : 8'h00);
  endfunction

  function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
    aes_byte_t acc;
    aes_byte_t p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Column c, row r lives at byte 15-4c-r, which is simply {~c, ~r}.
  function automatic logic [3:0] byte_idx(input logic [1:0] col, input logic [1:0] row);
    return {~col, ~row};
  endfunction

endpackage

// File: rtl/aes_mix_col_one.sv
// Combinational MixColumns of one 4-byte column, {a0,a1,a2,a3} with a0 in the MSBs.
// With AES_MIX_INV_EN defined, i_inv selects InvMixColumns.
module aes_mix_col_one
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
`ifdef AES_MIX_INV_EN
  input  logic        i_inv,
`endif
  output logic [31:0] o_col
);

  aes_byte_t   w_a0, w_a1, w_a2, w_a3;
  aes_byte_t   w_x0, w_x1, w_x2, w_x3;
  logic [31:0] w_fwd;

  assign {w_a0, w_a1, w_a2, w_a3} = i_col;

  assign w_x0 = xtime(w_a0);
  assign w_x1 = xtime(w_a1);
  assign w_x2 = xtime(w_a2);
  assign w_x3 = xtime(w_a3);

  // 3a is computed as 2a ^ a
  assign w_fwd = {w_x0 ^ w_x1 ^ w_a1 ^ w_a2 ^ w_a3,
                  w_a0 ^ w_x1 ^ w_x2 ^ w_a2 ^ w_a3,
                  w_a0 ^ w_a1 ^ w_x2 ^ w_x3 ^ w_a3,
                  w_x0 ^ w_a0 ^ w_a1 ^ w_a2 ^ w_x3};

`ifdef AES_MIX_INV_EN
  logic [31:0] w_inv;

  assign w_inv = {gf_mul(w_a0, 8'h0E) ^ gf_mul(w_a1, 8'h0B) ^ gf_mul(w_a2, 8'h0D) ^ gf_mul(w_a3, 8'h09),
                  gf_mul(w_a0, 8'h09) ^ gf_mul(w_a1, 8'h0E) ^ gf_mul(w_a2, 8'h0B) ^ gf_mul(w_a3, 8'h0D),
                  gf_mul(w_a0, 8'h0D) ^ gf_mul(w_a1, 8'h09) ^ gf_mul(w_a2, 8'h0E) ^ gf_mul(w_a3, 8'h0B),
                  gf_mul(w_a0, 8'h0B) ^ gf_mul(w_a1, 8'h0D) ^ gf_mul(w_a2, 8'h09) ^ gf_mul(w_a3, 8'h0E)};

  assign o_col = i_inv ? w_inv : w_fwd;
`else
  assign o_col = w_fwd;
`endif

endmodule

// File: rtl/aes_mix_columns_seq.sv
// Sequential MixColumns stage with valid/ready on both sides and a final-round bypass.
// COLS_PER_CYCLE columns (1, 2 or 4) are transformed in place per BUSY cycle.
// Optional macro AES_MIX_INV_EN adds in_inv to select InvMixColumns.
module aes_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bypass,
`ifdef AES_MIX_INV_EN
  input  logic       in_inv,
`endif
  input  aes_state_t in_state,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_state_t out_val
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("aes_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // col_cnt value at which the current pass writes column 3; wraps to 0 for 4 columns/cycle
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

  aes_mc_state_e r_state;
  aes_mc_state_e w_state_nxt;
  logic [1:0]    r_col_cnt;
  aes_state_t    r_work;
  aes_state_t    w_work_nxt;
  logic          w_load;
  logic          w_step;

  logic [1:0]    w_idx     [COLS_PER_CYCLE];
  logic [31:0]   w_col_in  [COLS_PER_CYCLE];
  logic [31:0]   w_col_out [COLS_PER_CYCLE];

`ifdef AES_MIX_INV_EN
  logic          r_inv;
`endif

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign w_idx[k]    = r_col_cnt + 2'(k);
    assign w_col_in[k] = {r_work[byte_idx(w_idx[k], 2'd0)],
                          r_work[byte_idx(w_idx[k], 2'd1)],
                          r_work[byte_idx(w_idx[k], 2'd2)],
                          r_work[byte_idx(w_idx[k], 2'd3)]};

    aes_mix_col_one u_col (
      .i_col (w_col_in[k]),
`ifdef AES_MIX_INV_EN
      .i_inv (r_inv),
`endif
      .o_col (w_col_out[k])
    );
  end

  // Merge the freshly transformed columns back into the work register image
  always_comb begin
    w_work_nxt = r_work;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      for (int r = 0; r < 4; r++) begin
        w_work_nxt[byte_idx(w_idx[k], 2'(r))] = w_col_out[k][8*(3-r) +: 8];
      end
    end
  end

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = in_bypass ? ST_BYPASS : ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_step = 1'b1;
        if (r_col_cnt == LAST_CNT) w_state_nxt = ST_DONE;
      end
      ST_BYPASS: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, column counter and work register; reset wins over any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_col_cnt <= 2'd0;
      r_work    <= '{default: '0};
`ifdef AES_MIX_INV_EN
      r_inv     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_work    <= in_state;
        r_col_cnt <= 2'd0;
`ifdef AES_MIX_INV_EN
        r_inv     <= in_inv;
`endif
      end else if (w_step) begin
        r_work    <= w_work_nxt;
        r_col_cnt <= r_col_cnt + CNT_STEP;
      end
    end
  end

  assign out_val = r_work;

endmodule
